// File: rtl/md_sched_if.sv
// Bundles the E/D-stage request signals and the HI/LO/stall responses of md_sched.
// The pipeline side uses the master modport and the scheduler uses the slave modport.
interface md_sched_if;
    logic        Start;
    logic [1:0]  MDOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        HI_we;
    logic        LO_we;
    logic        D_md;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        Busy;
    logic        MD_stall;

    modport master (
        output Start, MDOp, A, B, HI_we, LO_we, D_md,
        input  HI, LO, Busy, MD_stall
    );

    modport slave (
        input  Start, MDOp, A, B, HI_we, LO_we, D_md,
        output HI, LO, Busy, MD_stall
    );
endinterface

// File: rtl/md_sched.sv
// Multi-cycle mult/div scheduler for the MIPS pipeline: latches operands at issue,
// counts a fixed latency, commits the result into HI/LO and raises MD_stall meanwhile.
module md_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    md_sched_if.slave   bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MULT = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    logic [1:0]       op_q, op_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;

    logic        busy;
    logic        op_signed;
    logic [63:0] mul_a, mul_b, product;
    logic        a_neg, b_neg, div_zero;
    logic [31:0] a_mag, b_mag, div_den, q_mag, r_mag, quot, rem;
    logic [31:0] res_hi, res_lo;

    assign busy = (state_q != ST_IDLE);

    // One 64-bit multiplier serves both flavours: sign- or zero-extension picks the mode.
    always_comb begin
        op_signed = ~op_q[0];
        mul_a     = {{32{op_signed & a_q[31]}}, a_q};
        mul_b     = {{32{op_signed & b_q[31]}}, b_q};
        product   = mul_a * mul_b;
    end

    // Signed division runs on magnitudes so that 0x80000000 / -1 wraps cleanly to 0x80000000.
    always_comb begin
        a_neg    = op_signed & a_q[31];
        b_neg    = op_signed & b_q[31];
        a_mag    = a_neg ? (32'd0 - a_q) : a_q;
        b_mag    = b_neg ? (32'd0 - b_q) : b_q;
        div_zero = (b_q == 32'd0);
        div_den  = div_zero ? 32'd1 : b_mag;
        q_mag    = a_mag / div_den;
        r_mag    = a_mag % div_den;
        quot     = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        rem      = a_neg ? (32'd0 - r_mag) : r_mag;
    end

    always_comb begin
        res_hi = op_q[1] ? rem  : product[63:32];
        res_lo = op_q[1] ? quot : product[31:0];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.Start) begin
                    state_d = bus.MDOp[1] ? ST_DIV : ST_MULT;
                    cnt_d   = bus.MDOp[1] ? DIV_LOAD : MULT_LOAD;
                    a_d     = bus.A;
                    b_d     = bus.B;
                    op_d    = bus.MDOp;
                end else begin
                    if (bus.HI_we) hi_d = bus.A;
                    if (bus.LO_we) lo_d = bus.A;
                end
            end
            ST_MULT, ST_DIV: begin
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    // A divide by zero still spends its cycles but leaves HI/LO alone.
                    if (!(op_q[1] && div_zero)) begin
                        hi_d = res_hi;
                        lo_d = res_lo;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign bus.HI       = hi_q;
    assign bus.LO       = lo_q;
    assign bus.Busy     = busy;
    assign bus.MD_stall = bus.D_md & (bus.Start | busy);
endmodule

// File: tb/tb_md_sched.sv
// Randomised scoreboard bench for md_sched: a driver updates a cycle-level reference model
// and queues expected results; a negedge monitor checks Busy/MD_stall/HI/LO and pops on completion.
module tb_md_sched;
    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          n;
    } sb_entry_t;

    logic clk;
    logic reset;
    md_sched_if bus();

    md_sched #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int check_count = 0;
    int pass_count  = 0;

    sb_entry_t   scoreboard[$];
    int          rem      = 0;
    logic [31:0] arch_hi  = '0;
    logic [31:0] arch_lo  = '0;
    logic [31:0] pend_hi  = '0;
    logic [31:0] pend_lo  = '0;
    logic        pend_zero = 1'b0;
    logic        aborted  = 1'b0;
    logic        mon_en   = 1'b0;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_count++;
        if (act === exp) pass_count++;
        else $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference arithmetic straight from the ISA definition, using 64-bit integers.
    function automatic void ref_calc(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] hi, output logic [31:0] lo, output logic zero);
        longint          sa, sbv, sp, q, r;
        longint unsigned ua, ub, up, uq, ur;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        ua  = {32'h0, a};
        ub  = {32'h0, b};
        zero = 1'b0;
        hi = '0;
        lo = '0;
        case (op)
            2'b00: begin sp = sa * sbv; hi = sp[63:32]; lo = sp[31:0]; end
            2'b01: begin up = ua * ub;  hi = up[63:32]; lo = up[31:0]; end
            2'b10: begin
                if (b == 32'd0) zero = 1'b1;
                else begin q = sa / sbv; r = sa % sbv; hi = r[31:0]; lo = q[31:0]; end
            end
            default: begin
                if (b == 32'd0) zero = 1'b1;
                else begin uq = ua / ub; ur = ua % ub; hi = ur[31:0]; lo = uq[31:0]; end
            end
        endcase
    endfunction

    task automatic model_edge();
        sb_entry_t e;
        if (!reset) begin
            if (rem > 0) aborted = 1'b1;
            rem = 0;
            arch_hi = '0;
            arch_lo = '0;
            scoreboard.delete();
        end else if (rem > 0) begin
            if (rem == 1 && !pend_zero) begin
                arch_hi = pend_hi;
                arch_lo = pend_lo;
            end
            rem--;
        end else if (bus.Start) begin
            ref_calc(bus.MDOp, bus.A, bus.B, pend_hi, pend_lo, pend_zero);
            rem  = bus.MDOp[1] ? DIV_CYCLES : MULT_CYCLES;
            e.hi = pend_zero ? arch_hi : pend_hi;
            e.lo = pend_zero ? arch_lo : pend_lo;
            e.n  = rem;
            scoreboard.push_back(e);
        end else begin
            if (bus.HI_we) arch_hi = bus.A;
            if (bus.LO_we) arch_lo = bus.A;
        end
    endtask

    task automatic apply_stimulus(input logic rst_n, input logic start, input logic [1:0] op,
                                  input logic [31:0] a, input logic [31:0] b,
                                  input logic hw, input logic lw, input logic dmd);
        reset     = rst_n;
        bus.Start = start;
        bus.MDOp  = op;
        bus.A     = a;
        bus.B     = b;
        bus.HI_we = hw;
        bus.LO_we = lw;
        bus.D_md  = dmd;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_cycles(input int n, input logic dmd);
        for (int i = 0; i < n; i++) apply_stimulus(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, dmd);
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: per-cycle Busy/MD_stall/HI/LO checks, and a scoreboard pop on each Busy fall.
    initial begin
        logic      prev_busy;
        int        run;
        sb_entry_t e;
        prev_busy = 1'b0;
        run = 0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                check_output("busy", 32'(bus.Busy), 32'(rem > 0));
                check_output("md_stall", 32'(bus.MD_stall), 32'(bus.D_md & (bus.Start | (rem > 0))));
                check_output("hi", bus.HI, arch_hi);
                check_output("lo", bus.LO, arch_lo);
                if (bus.Busy === 1'b1) run++;
                if (prev_busy && bus.Busy !== 1'b1) begin
                    if (aborted) begin
                        aborted = 1'b0;
                    end else begin
                        check_output("sb_nonempty", 32'(scoreboard.size() > 0), 32'd1);
                        if (scoreboard.size() > 0) begin
                            e = scoreboard.pop_front();
                            check_output("sb_hi", bus.HI, e.hi);
                            check_output("sb_lo", bus.LO, e.lo);
                            check_output("busy_len", 32'(run), 32'(e.n));
                        end
                    end
                    run = 0;
                end
                prev_busy = (bus.Busy === 1'b1);
            end
        end
    end

    initial begin
        // Reset held two cycles with Start asserted and an MD instruction in D.
        apply_stimulus(1'b0, 1'b1, 2'b10, 32'h5, 32'h3, 1'b1, 1'b1, 1'b1);
        mon_en = 1'b1;
        apply_stimulus(1'b0, 1'b1, 2'b10, 32'h5, 32'h3, 1'b1, 1'b1, 1'b1);
        check_output("rst_busy", 32'(bus.Busy), 32'd0);
        check_output("rst_hi", bus.HI, 32'h0);
        idle_cycles(1, 1'b0);

        // mult -3 * 7
        apply_stimulus(1'b1, 1'b1, 2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0, 1'b0);
        idle_cycles(MULT_CYCLES, 1'b0);
        check_output("mult_hi", bus.HI, 32'hFFFF_FFFF);
        check_output("mult_lo", bus.LO, 32'hFFFF_FFEB);

        // multu 0xFFFFFFFF * 2
        apply_stimulus(1'b1, 1'b1, 2'b01, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0, 1'b0);
        idle_cycles(MULT_CYCLES, 1'b0);
        check_output("multu_hi", bus.HI, 32'h0000_0001);
        check_output("multu_lo", bus.LO, 32'hFFFF_FFFE);

        // div -7 / 2 with an MD instruction waiting in D the whole time
        apply_stimulus(1'b1, 1'b1, 2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 1'b1);
        idle_cycles(DIV_CYCLES, 1'b1);
        check_output("div_stall_clear", 32'(bus.MD_stall), 32'd0);
        check_output("div_hi", bus.HI, 32'hFFFF_FFFF);
        check_output("div_lo", bus.LO, 32'hFFFF_FFFD);

        // Signed overflow corner
        apply_stimulus(1'b1, 1'b1, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        idle_cycles(DIV_CYCLES, 1'b0);
        check_output("ovf_hi", bus.HI, 32'h0);
        check_output("ovf_lo", bus.LO, 32'h8000_0000);

        // mthi/mtlo preset, then divu by zero leaves them intact
        apply_stimulus(1'b1, 1'b0, 2'b00, 32'h11, 32'h0, 1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 2'b00, 32'h22, 32'h0, 1'b0, 1'b1, 1'b0);
        apply_stimulus(1'b1, 1'b1, 2'b11, 32'd7, 32'd0, 1'b1, 1'b1, 1'b0);
        idle_cycles(DIV_CYCLES, 1'b0);
        check_output("dz_hi", bus.HI, 32'h11);
        check_output("dz_lo", bus.LO, 32'h22);

        // Reset during busy cycle 3 aborts the multiply
        apply_stimulus(1'b1, 1'b1, 2'b00, 32'd9, 32'd9, 1'b0, 1'b0, 1'b0);
        idle_cycles(2, 1'b0);
        apply_stimulus(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        check_output("abort_busy", 32'(bus.Busy), 32'd0);
        idle_cycles(8, 1'b0);
        check_output("abort_hi", bus.HI, 32'h0);
        check_output("abort_lo", bus.LO, 32'h0);

        // Random traffic, including requests while busy and occasional resets
        for (int i = 0; i < 600; i++) begin
            apply_stimulus(($urandom_range(0, 99) != 0), ($urandom_range(0, 4) == 0),
                           2'($urandom_range(0, 3)), rand_operand(), rand_operand(),
                           ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                           1'($urandom_range(0, 1)));
        end
        idle_cycles(DIV_CYCLES + 4, 1'b0);
        check_output("sb_drained", 32'(scoreboard.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end
endmodule

// File: doc/md_sched.md
Name: md_sched

Overview:
- Multi-cycle multiply/divide scheduler for the 5-stage MIPS pipeline.
- Accepts mult/multu/div/divu issued from the E stage and sequences the operation over a fixed number of busy cycles.
- Owns the HI/LO registers and services mthi/mtlo writes.
- Generates MD_stall, which the hazard unit ORs into its existing stall term. That stall freezes PC/D and clears E.

Parameters:
MULT_CYCLES  5  busy cycles for mult/multu (1..2^CNT_W-1)
DIV_CYCLES  10  busy cycles for div/divu (1..2^CNT_W-1)
CNT_W  4  width of the busy countdown counter

Ports:
clk  in  1  pipeline clock, all state updates on rising edge
reset  in  1  synchronous, active-low; sampled on rising edge of clk
Start  in  1  E-stage instruction is mult/multu/div/divu (issue strobe, one cycle)
MDOp  in  2  00 mult, 01 multu, 10 div, 11 divu; valid with Start
A  in  32  E-stage forwarded rs value; also the mthi/mtlo write data
B  in  32  E-stage forwarded rt value
HI_we  in  1  E-stage mthi
LO_we  in  1  E-stage mtlo
D_md  in  1  D-stage instruction is any of mult/multu/div/divu/mfhi/mflo/mthi/mtlo
HI  out  32  HI register
LO  out  32  LO register
Busy  out  1  operation in progress
MD_stall  out  1  stall request to hazard unit

Behaviour:
- Reset: when reset==0 at a clock edge, the next state is as follows:
  - State=IDLE, counter=0, Busy=0.
  - HI=0, LO=0, operand and result latches=0.
  - Any in-flight operation is aborted with no HI/LO write.
  - Reset overrides all other inputs.
- States:
  - IDLE -> MULT on Start with MDOp[1]==0.
  - IDLE -> DIV on Start with MDOp[1]==1.
  - MULT/DIV -> IDLE when counter==1 at a clock edge.
- Issue (cycle t, Start=1 in IDLE):
  - Latch A, B and MDOp at the edge ending t.
  - Counter loads MULT_CYCLES or DIV_CYCLES.
- Busy:
  - Busy = (state!=IDLE), registered.
  - Busy is high for exactly N cycles, t+1..t+N, where N is the selected latency.
  - The counter decrements each busy cycle.
- Commit: at the edge ending cycle t+N, HI/LO take the result; new values are visible in cycle t+N+1, which is also when Busy=0.
- Arithmetic, on the latched operands; the result is precomputed at issue or on the final cycle (implementer's choice), but must be exact:
  - mult: {HI,LO} = signed(A)*signed(B), 64-bit.
  - multu: {HI,LO} = unsigned 64-bit product.
  - div: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend (signed).
  - divu: unsigned quotient and remainder.
  - Division by zero: Busy still runs DIV_CYCLES; HI/LO are left unchanged at commit.
  - Signed div of 0x80000000 by 0xFFFFFFFF: LO=0x80000000, HI=0.
- mthi/mtlo:
  - In IDLE with Start=0, HI_we writes HI<=A and LO_we writes LO<=A at the same edge (single cycle).
  - HI_we and LO_we may both be high together.
- Simultaneous events:
  - Start with HI_we/LO_we: Start wins; the writes are ignored.
  - Start, HI_we or LO_we while Busy: ignored, state unaffected. The pipeline prevents this via MD_stall.
- MD_stall = D_md & (Start | Busy), combinational.
  - Any MD-class instruction in D waits until HI/LO are final.
  - This includes an instruction directly behind an issuing one (Start=1).
  - Non-MD instructions proceed while Busy.
- HI/LO outputs are register values (no bypass of the pending result); mfhi/mflo read them in E after any stall clears.

Test Plan:
- Reset: hold reset=0 two cycles with Start=1 -> HI=0, LO=0, Busy=0, MD_stall=D_md&Start only; release -> IDLE.
- mult: A=0xFFFFFFFD (-3), B=7, Start one cycle -> Busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFEB; HI/LO unchanged during busy.
- multu: A=0xFFFFFFFF, B=2 -> HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles.
- div: A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF after 10 busy cycles.
- divu by zero: HI=0x11, LO=0x22 preset via mthi/mtlo; A=7, B=0 -> Busy 10 cycles; HI=0x11, LO=0x22 afterwards.
- Stall/reset mid-op:
  - D_md=1 throughout a div -> MD_stall=1 from the Start cycle through the last busy cycle, 0 in the commit-visible cycle.
  - A mid-operation reset at busy cycle 3 -> Busy=0 next cycle; HI/LO=0; no later commit.
